fetch_stage: RTL

Instruction-fetch stage directly downstream of the program counter. Takes the current PC, issues a read to a multi-cycle instruction memory and waits for completion. Drives PcStall back to the PC so the PC holds until the fetch is accepted. Loads the fetched instruction and PC+2 into the IF/ID pipeline register, with support for decode stalls, branch/jump flushes, halt and a memory-timeout error.

---
 rtl/fetch_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues PC reads to a multi-cycle instruction memory,
// stalls the PC until a fetch lands in IF/ID, and handles stall/flush/halt/timeout.
module fetch_stage #(
  parameter logic [15:0] NOP_INSTR  = 16'h0800,
  parameter int unsigned WAIT_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC,
  input  logic        IdStall,
  input  logic        Flush,
  input  logic        Halt,
  input  logic        ImemBusy,
  input  logic        ImemDone,
  input  logic [15:0] ImemRdata,
  output logic        ImemRd,
  output logic [15:0] ImemAddr,
  output logic        PcStall,
  output logic [15:0] IfId_Instr,
  output logic [15:0] IfId_PcPlus2,
  output logic        IfId_Valid,
  output logic        Err
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALTED} state_t;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [15:0] pc2_q;
  logic [15:0] hold_q;
  logic        squash_q;
  logic [15:0] instr_q;
  logic [15:0] ifpc2_q;
  logic        valid_q;
  logic        err_q;

  logic        issue;
  logic        discard;
  logic        load_wait;
  logic        load_hold;
  logic        load;
  logic [15:0] load_instr_d;
  logic [7:0]  cnt_d;

  always_comb begin
    issue        = (state_q == REQ) && !ImemBusy && !Halt && !Flush;
    discard      = (state_q == WAIT) && ImemDone && (squash_q || Flush);
    load_wait    = (state_q == WAIT) && ImemDone && !discard && !IdStall;
    load_hold    = (state_q == HOLD) && !Flush && !IdStall;
    load         = load_wait || load_hold;
    load_instr_d = load_hold ? hold_q : ImemRdata;
    // Counter saturates so a very long wait never wraps back past the limit.
    cnt_d        = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  assign ImemRd       = issue;
  assign ImemAddr     = issue ? PC : 16'h0000;
  assign PcStall      = !load;
  assign IfId_Instr   = instr_q;
  assign IfId_PcPlus2 = ifpc2_q;
  assign IfId_Valid   = valid_q;
  assign Err          = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= REQ;
      cnt_q    <= 8'd0;
      pc2_q    <= 16'h0000;
      hold_q   <= 16'h0000;
      squash_q <= 1'b0;
      instr_q  <= NOP_INSTR;
      ifpc2_q  <= 16'h0000;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // IF/ID register: flush beats load beats hold beats bubble.
      if (Flush) begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end else if (load) begin
        valid_q <= 1'b1;
        instr_q <= load_instr_d;
        ifpc2_q <= pc2_q;
      end else if (!IdStall && state_q != HALTED) begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end

      unique case (state_q)
        REQ: begin
          if (Halt) begin
            state_q <= HALTED;
          end else if (issue) begin
            pc2_q   <= PC + 16'd2;
            cnt_q   <= 8'd0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d == LIMIT) err_q <= 1'b1;
          if (ImemDone) begin
            if (discard) begin
              squash_q <= 1'b0;
              state_q  <= REQ;
            end else if (!IdStall) begin
              state_q <= REQ;
            end else begin
              hold_q  <= ImemRdata;
              state_q <= HOLD;
            end
          end else if (Flush) begin
            squash_q <= 1'b1;
          end
        end
        HOLD: begin
          if (Flush || !IdStall) state_q <= REQ;
        end
        default: state_q <= HALTED;
      endcase
    end
  end

endmodule
